// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM port arbiter
package ram_arb_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_REGISTER_COUNT = 256;
  localparam int DEF_AW = $clog2(DEF_REGISTER_COUNT);
  localparam int DEF_MAX_WAIT = 4;
  typedef enum logic {OWNER_CPU, OWNER_DMA} owner_t;
  typedef struct packed {
    logic we;
    logic [DEF_AW-1:0] addr;
    logic [DEF_WIDTH-1:0] wdata;
  } ram_req_t;
endpackage

// File: rtl/ram_arb_starve_ctr.sv
// ram_arb_starve_ctr: counts denied DMA cycles and forces a DMA grant at MAX_WAIT
module ram_arb_starve_ctr
  import ram_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic CPUclk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_dma
);
  logic [3:0] cnt;
  always_ff @(posedge CPUclk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!dma_req || dma_gnt) ? 4'd0 : (cnt == 4'(MAX_WAIT)) ? cnt : cnt + 4'd1;
  assign force_dma = dma_req && (cnt == 4'(MAX_WAIT));
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: CPU-priority sharing of the RAM rw port with a DMA master
// Define RAM_PORT_ARB_STARVE_GUARD_EN to bound DMA starvation at MAX_WAIT cycles.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGISTER_COUNT = DEF_REGISTER_COUNT,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  localparam int AW = $clog2(REGISTER_COUNT)
) (
  input  logic CPUclk,
  input  logic rst,
  input  logic cpu_req,
  input  logic cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic cpu_gnt,
  output logic cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic dma_req,
  input  logic dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic dma_gnt,
  output logic dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic ram_we,
  input  logic [WIDTH-1:0] ram_rdata
);
  logic force_dma;
  logic pending;
  owner_t owner;
  ram_req_t cpu_r, dma_r, sel;
`ifdef RAM_PORT_ARB_STARVE_GUARD_EN
  ram_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_ctr (
    .CPUclk(CPUclk),
    .rst(rst),
    .dma_req(dma_req),
    .dma_gnt(dma_gnt),
    .force_dma(force_dma)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
  assign force_dma = 1'b0;
`endif
  assign cpu_gnt = !rst && cpu_req && !force_dma;
  assign dma_gnt = !rst && dma_req && (!cpu_req || force_dma);
  assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_r = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
  assign sel = dma_gnt ? dma_r : cpu_gnt ? cpu_r : ram_req_t'('0);
  assign ram_we = sel.we;
  assign ram_addr = sel.addr;
  assign ram_wdata = sel.wdata;
  always_ff @(posedge CPUclk or posedge rst)
    if (rst) begin
      pending <= 1'b0;
      owner <= OWNER_CPU;
    end else begin
      pending <= (cpu_gnt || dma_gnt) && !sel.we;
      owner <= dma_gnt ? OWNER_DMA : OWNER_CPU;
    end
  assign cpu_rvalid = pending && (owner == OWNER_CPU);
  assign dma_rvalid = pending && (owner == OWNER_DMA);
  // read data only surfaces while a read is returning, so reset leaves it at 0
  assign cpu_rdata = pending ? ram_rdata : '0;
  assign dma_rdata = pending ? ram_rdata : '0;
endmodule
